fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined Harvard CPU, sitting directly upstream of the program memory and the decode stage. Owns the program counter and drives it to the combinational program memory. Captures the returned 16-bit instruction into the IF/ID pipeline register. Handles stall, branch/jump redirect with flush, HALT detection and PC wrap-around.

---
 rtl/fetch_stage.sv | 65 ++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, captures the returned
// instruction into the IF/ID register, and handles stall, redirect and HALT.
module fetch_stage #(
    parameter int                A_BITS    = 5,
    parameter int                I_BITS    = 16,
    parameter logic [I_BITS-1:0] NOP_WORD  = 16'h0000,
    parameter logic [I_BITS-1:0] HALT_WORD = 16'h0001,
    parameter int                CNT_BITS  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [A_BITS-1:0]   pc,
    input  logic [I_BITS-1:0]   instr,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [A_BITS-1:0]   redirect_pc,
    output logic [I_BITS-1:0]   id_instr,
    output logic [A_BITS-1:0]   id_pc,
    output logic                id_valid,
    output logic                halted,
    output logic [CNT_BITS-1:0] fetch_count
);

    logic [A_BITS-1:0] pc_q;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign pc = pc_q;

    // Priority per edge: redirect, then stall, then halted, then normal fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            id_instr    <= NOP_WORD;
            id_pc       <= '0;
            id_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else if (redirect_valid) begin
            // Wrong-path fetch (including any HALT) is squashed; id_pc keeps its value.
            pc_q     <= redirect_pc;
            id_instr <= NOP_WORD;
            id_valid <= 1'b0;
            halted   <= 1'b0;
        end else if (stall) begin
            pc_q     <= pc_q;
        end else if (halted) begin
            id_instr <= NOP_WORD;
            id_valid <= 1'b0;
        end else begin
            id_instr    <= instr;
            id_pc       <= pc_q;
            id_valid    <= 1'b1;
            fetch_count <= sat_inc(fetch_count);
            if (instr == HALT_WORD) begin
                halted <= 1'b1;
            end else begin
                pc_q <= pc_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-edge expectations are queued when inputs are
// driven and compared once the edge has produced the registered outputs.
module tb_fetch_stage;

    localparam int A_BITS   = 5;
    localparam int I_BITS   = 16;
    localparam int CNT_BITS = 4;
    localparam logic [15:0] NOP  = 16'h0000;
    localparam logic [15:0] HALT = 16'h0001;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [A_BITS-1:0]   pc;
    logic [I_BITS-1:0]   instr;
    logic                stall;
    logic                redirect_valid;
    logic [A_BITS-1:0]   redirect_pc;
    logic [I_BITS-1:0]   id_instr;
    logic [A_BITS-1:0]   id_pc;
    logic                id_valid;
    logic                halted;
    logic [CNT_BITS-1:0] fetch_count;

    logic [15:0] mem [32];

    fetch_stage #(
        .A_BITS(A_BITS), .I_BITS(I_BITS), .NOP_WORD(NOP), .HALT_WORD(HALT),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    assign instr = mem[pc];

    always #5 clk = ~clk;

    typedef struct {
        logic [A_BITS-1:0]   pc;
        logic [15:0]         ii;
        logic [A_BITS-1:0]   ip;
        logic                iv;
        logic                h;
        logic [CNT_BITS-1:0] cnt;
    } exp_t;

    exp_t sbq[$];

    logic [A_BITS-1:0]   m_pc, m_ip;
    logic [15:0]         m_ii;
    logic                m_iv, m_h;
    logic [CNT_BITS-1:0] m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_ip = '0; m_ii = NOP; m_iv = 1'b0; m_h = 1'b0; m_cnt = '0;
        sbq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"}, 32'(pc), 32'd0);
        chk({tag, "_id_instr"}, 32'(id_instr), 32'(NOP));
        chk({tag, "_id_pc"}, 32'(id_pc), 32'd0);
        chk({tag, "_id_valid"}, 32'(id_valid), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_cnt"}, 32'(fetch_count), 32'd0);
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then compare.
    task automatic step(input logic s, input logic r, input logic [A_BITS-1:0] rpc);
        exp_t e;
        logic [15:0] cur;
        @(negedge clk);
        stall = s; redirect_valid = r; redirect_pc = rpc;
        cur = mem[m_pc];
        if (r) begin
            m_pc = rpc; m_ii = NOP; m_iv = 1'b0; m_h = 1'b0;
        end else if (s) begin
            m_pc = m_pc;
        end else if (m_h) begin
            m_ii = NOP; m_iv = 1'b0;
        end else begin
            m_ii = cur; m_ip = m_pc; m_iv = 1'b1;
            if (m_cnt != {CNT_BITS{1'b1}}) m_cnt = m_cnt + 1'b1;
            if (cur == HALT) m_h = 1'b1;
            else m_pc = m_pc + 1'b1;
        end
        e.pc = m_pc; e.ii = m_ii; e.ip = m_ip; e.iv = m_iv; e.h = m_h; e.cnt = m_cnt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk("sb_pc", 32'(pc), 32'(e.pc));
            chk("sb_id_instr", 32'(id_instr), 32'(e.ii));
            chk("sb_id_pc", 32'(id_pc), 32'(e.ip));
            chk("sb_id_valid", 32'(id_valid), 32'(e.iv));
            chk("sb_halted", 32'(halted), 32'(e.h));
            chk("sb_cnt", 32'(fetch_count), 32'(e.cnt));
        end
        stall = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CNT_BITS-1:0] cnt_save;
        logic [15:0]         ii_save;

        for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
        mem[5] = HALT;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        rst_n = 1'b0;
        #12;
        check_reset_outputs("reset");
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;

        // Free run into HALT at word 5.
        step(0, 0, 0);
        chk("first_id_pc", 32'(id_pc), 32'd0);
        chk("first_id_instr", 32'(id_instr), 32'hA000);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        chk("halt_set", 32'(halted), 32'd1);
        chk("halt_id_instr", 32'(id_instr), 32'(HALT));
        step(0, 0, 0);
        chk("halt_pc_hold", 32'(pc), 32'd5);
        chk("halt_bubble", 32'(id_valid), 32'd0);
        chk("halt_cnt", 32'(fetch_count), 32'd6);
        step(0, 0, 0);

        // Stall for three cycles at pc=2.
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        cnt_save = fetch_count;
        ii_save  = id_instr;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            chk("stall_pc", 32'(pc), 32'd2);
            chk("stall_cnt", 32'(fetch_count), 32'(cnt_save));
            chk("stall_id_instr", 32'(id_instr), 32'(ii_save));
        end
        step(0, 0, 0);
        chk("resume_id_pc", 32'(id_pc), 32'd2);
        chk("resume_id_instr", 32'(id_instr), 32'hA002);

        // Redirect to 9 overrides a simultaneous stall at pc=4.
        step(0, 0, 0);
        chk("pre_redir_pc", 32'(pc), 32'd4);
        cnt_save = fetch_count;
        step(1, 1, 9);
        chk("redir_pc", 32'(pc), 32'd9);
        chk("redir_bubble", 32'(id_valid), 32'd0);
        chk("redir_nop", 32'(id_instr), 32'(NOP));
        chk("redir_cnt", 32'(fetch_count), 32'(cnt_save));
        step(0, 0, 0);
        chk("redir_id_pc", 32'(id_pc), 32'd9);

        // HALT cancelled by a following redirect.
        step(0, 1, 5);
        step(0, 0, 0);
        chk("halt2_set", 32'(halted), 32'd1);
        step(0, 1, 12);
        chk("unhalt", 32'(halted), 32'd0);
        chk("unhalt_pc", 32'(pc), 32'd12);
        step(0, 0, 0);
        chk("unhalt_id_pc", 32'(id_pc), 32'd12);

        // PC wrap-around from 31 to 0.
        step(0, 1, 30);
        step(0, 0, 0);
        chk("wrap_pc31", 32'(pc), 32'd31);
        step(0, 0, 0);
        chk("wrap_pc0", 32'(pc), 32'd0);
        chk("wrap_id_pc31", 32'(id_pc), 32'd31);
        step(0, 0, 0);
        chk("wrap_id_pc0", 32'(id_pc), 32'd0);
        chk("wrap_pc1", 32'(pc), 32'd1);

        // Counter saturation.
        chk("cnt_sat", 32'(fetch_count), 32'hF);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("cnt_sat_hold", 32'(fetch_count), 32'hF);

        // Asynchronous reset while halted with fetch_count=7.
        @(negedge clk); rst_n = 1'b0;
        #1 check_reset_outputs("rst2");
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        mem[5] = 16'hA005;
        mem[6] = HALT;
        for (int i = 0; i < 7; i++) step(0, 0, 0);
        chk("pre_async_halted", 32'(halted), 32'd1);
        chk("pre_async_cnt", 32'(fetch_count), 32'd7);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        step(0, 0, 0);
        chk("restart_pc", 32'(pc), 32'd1);
        chk("restart_id_pc", 32'(id_pc), 32'd0);
        chk("restart_id_instr", 32'(id_instr), 32'hA000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
